// File: rtl/timing_mon_pkg.sv
// Purpose: shared definitions for replica-based timing monitors.
//   - mon_state_e : measurement FSM state encoding (IDLE/SETTLE/MEASURE/REPORT)
//   - DEF_*       : default window length, alarm threshold and miss-counter width,
//                   so monitors attached to different replica chains agree
//   - cnt_width() : bit width of a down-counter that is loaded with n-1
// Ports: none (package).
package timing_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_MEASURE = 2'd2,
        ST_REPORT  = 2'd3
    } mon_state_e;

    localparam int unsigned DEF_WINDOW = 32'd256;
    localparam int unsigned DEF_THRESH = 32'd4;
    localparam int unsigned DEF_CNT_W  = 32'd16;

    // Width needed to hold n-1 in a down-counter; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        int unsigned w;
        if (n > 32'd1) begin
            w = $clog2(n);
        end else begin
            w = 32'd1;
        end
        return w;
    endfunction

endpackage

// File: rtl/replica_launch_capture.sv
// Purpose: launch/capture pair around the delay-replica chain.
//   A toggle flop launches a fresh edge into the replica every enabled cycle;
//   at the next clock edge the replica output is compared with the value that
//   was launched, and any disagreement (a late arrival) is registered as a miss.
// Ports:
//   clk_i          core clock
//   rst_ni         asynchronous reset, active-low
//   toggle_en_i    1 = toggle the launch flop this edge
//   compare_en_i   1 = this edge's compare result is valid
//   replica_out_i  replica chain output
//   launch_o       launch flop output (drives the replica input, no logic after the flop)
//   miss_o         registered miss, one cycle after the failing edge
module replica_launch_capture #(
    parameter bit REPLICA_INVERTS = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic toggle_en_i,
    input  logic compare_en_i,
    input  logic replica_out_i,
    output logic launch_o,
    output logic miss_o
);

    logic launch_r;
    logic miss_r;
    logic miss_raw_s;

    // Compare the parity-corrected replica output with the value launched last edge.
    always_comb begin
        miss_raw_s = ((replica_out_i ^ REPLICA_INVERTS) != launch_r);
    end

    // Launch toggle flop: a new edge every enabled cycle, held otherwise.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            launch_r <= 1'b0;
        end else if (toggle_en_i) begin
            launch_r <= ~launch_r;
        end else begin
            launch_r <= launch_r;
        end
    end

    // Miss register: only compares made inside a measurement window count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            miss_r <= 1'b0;
        end else begin
            miss_r <= compare_en_i & miss_raw_s;
        end
    end

    assign launch_o = launch_r;
    assign miss_o   = miss_r;

endmodule

// File: rtl/replica_timing_monitor.sv
// Purpose: replica timing monitor. Runs back-to-back measurement windows
//   (SETTLE then MEASURE then one REPORT cycle), counts late-arrival misses of
//   the delay replica per window and raises a sticky alarm when a window's
//   count reaches THRESH.
// Ports:
//   clk_i          core clock
//   rst_ni         asynchronous reset, active-low
//   enable_i       level; 1 = run measurement windows back-to-back
//   clear_i        pulse; clears alarm_o and miss_count_o
//   replica_in_o   launch flop output, drives the replica chain input
//   replica_out_i  replica chain output
//   miss_o         one-cycle pulse per detected miss
//   miss_count_o   misses counted in current or last window (saturating)
//   window_done_o  one-cycle pulse in the REPORT cycle
//   alarm_o        sticky over-threshold flag
//   busy_o         high in SETTLE or MEASURE
module replica_timing_monitor
    import timing_mon_pkg::*;
#(
    parameter bit          REPLICA_INVERTS = 1'b0,
    parameter int unsigned WINDOW          = DEF_WINDOW,
    parameter int unsigned THRESH          = DEF_THRESH,
    parameter int unsigned SETTLE          = 32'd2,
    parameter int unsigned CNT_W           = DEF_CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             enable_i,
    input  logic             clear_i,
    output logic             replica_in_o,
    input  logic             replica_out_i,
    output logic             miss_o,
    output logic [CNT_W-1:0] miss_count_o,
    output logic             window_done_o,
    output logic             alarm_o,
    output logic             busy_o
);

    localparam int unsigned WIN_W = cnt_width(WINDOW);
    localparam int unsigned SET_W = cnt_width(SETTLE);
    localparam logic [WIN_W-1:0] WIN_LOAD = WIN_W'(WINDOW - 32'd1);
    localparam logic [SET_W-1:0] SET_LOAD = SET_W'(SETTLE - 32'd1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    mon_state_e       state_r;
    mon_state_e       state_next_s;
    logic [SET_W-1:0] set_cnt_r;
    logic [WIN_W-1:0] win_cnt_r;
    logic [CNT_W-1:0] miss_count_r;
    logic [CNT_W-1:0] cnt_final_s;
    logic             alarm_r;
    logic             done_r;
    logic             busy_r;
    logic             miss_s;
    logic             toggle_en_s;
    logic             compare_en_s;
    logic             enter_measure_s;
    logic             load_settle_s;
    logic             alarm_hit_s;

    replica_launch_capture #(
        .REPLICA_INVERTS (REPLICA_INVERTS)
    ) u_launch_capture (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .toggle_en_i   (toggle_en_s),
        .compare_en_i  (compare_en_s),
        .replica_out_i (replica_out_i),
        .launch_o      (replica_in_o),
        .miss_o        (miss_s)
    );

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic; dropping enable abandons a window from SETTLE or MEASURE.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (enable_i) state_next_s = ST_SETTLE;
                else          state_next_s = ST_IDLE;
            end
            ST_SETTLE: begin
                if (!enable_i)                     state_next_s = ST_IDLE;
                else if (set_cnt_r == {SET_W{1'b0}}) state_next_s = ST_MEASURE;
                else                               state_next_s = ST_SETTLE;
            end
            ST_MEASURE: begin
                if (!enable_i)                     state_next_s = ST_IDLE;
                else if (win_cnt_r == {WIN_W{1'b0}}) state_next_s = ST_REPORT;
                else                               state_next_s = ST_MEASURE;
            end
            ST_REPORT: begin
                if (enable_i) state_next_s = ST_SETTLE;
                else          state_next_s = ST_IDLE;
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // FSM output decode: launch, compare and counter-load controls.
    always_comb begin
        toggle_en_s     = 1'b0;
        compare_en_s    = 1'b0;
        enter_measure_s = 1'b0;
        load_settle_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                load_settle_s = (state_next_s == ST_SETTLE);
            end
            ST_SETTLE: begin
                toggle_en_s     = 1'b1;
                enter_measure_s = (state_next_s == ST_MEASURE);
            end
            ST_MEASURE: begin
                toggle_en_s  = 1'b1;
                // An edge on which the window is being abandoned is not judged.
                compare_en_s = enable_i;
            end
            ST_REPORT: begin
                toggle_en_s   = 1'b1;
                load_settle_s = (state_next_s == ST_SETTLE);
            end
            default: begin
                toggle_en_s = 1'b0;
            end
        endcase
    end

    // Count including the miss currently visible; REPORT uses it to judge the
    // window because the last compare's miss only lands in that cycle.
    always_comb begin
        if (miss_s && (miss_count_r != CNT_MAX)) begin
            cnt_final_s = miss_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_final_s = miss_count_r;
        end
        alarm_hit_s = (state_r == ST_REPORT) && (32'(cnt_final_s) >= THRESH);
    end

    // Settle and window down-counters.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            set_cnt_r <= {SET_W{1'b0}};
            win_cnt_r <= {WIN_W{1'b0}};
        end else begin
            if (load_settle_s) begin
                set_cnt_r <= SET_LOAD;
            end else if ((state_r == ST_SETTLE) && (set_cnt_r != {SET_W{1'b0}})) begin
                set_cnt_r <= set_cnt_r - {{(SET_W-1){1'b0}}, 1'b1};
            end else begin
                set_cnt_r <= set_cnt_r;
            end
            if (enter_measure_s) begin
                win_cnt_r <= WIN_LOAD;
            end else if ((state_r == ST_MEASURE) && (win_cnt_r != {WIN_W{1'b0}})) begin
                win_cnt_r <= win_cnt_r - {{(WIN_W-1){1'b0}}, 1'b1};
            end else begin
                win_cnt_r <= win_cnt_r;
            end
        end
    end

    // Miss counter: clear beats a new window, which beats a saturating increment.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            miss_count_r <= {CNT_W{1'b0}};
        end else if (clear_i || enter_measure_s) begin
            miss_count_r <= {CNT_W{1'b0}};
        end else begin
            miss_count_r <= cnt_final_s;
        end
    end

    // Sticky alarm: a REPORT that crosses the threshold wins over clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            alarm_r <= 1'b0;
        end else if (alarm_hit_s) begin
            alarm_r <= 1'b1;
        end else if (clear_i) begin
            alarm_r <= 1'b0;
        end else begin
            alarm_r <= alarm_r;
        end
    end

    // Status flags registered from the next state so they line up with state_r.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            done_r <= 1'b0;
            busy_r <= 1'b0;
        end else begin
            done_r <= (state_next_s == ST_REPORT);
            busy_r <= (state_next_s == ST_SETTLE) || (state_next_s == ST_MEASURE);
        end
    end

    assign miss_o        = miss_s;
    assign miss_count_o  = miss_count_r;
    assign alarm_o       = alarm_r;
    assign window_done_o = done_r;
    assign busy_o        = busy_r;

endmodule
